link_spi_controller: RTL and testbench
======================================

Name: link_spi_controller

Overview:
- Sequences the SPI link layer packet by packet, using the control strobes the link produces: packet start, end, error, address, command and size.
- Commits or rolls back the MIL transmit buffer for send-data packets.
- Arms the in-packet reply path for status and receive-data requests.
- Issues the system reset request.
- Keeps the packet ok/error counters that are returned in the status reply.

Parameters:
- RESET_LEN, 16: width in clk cycles of the rstRequest pulse (range 1..255).
- TIMEOUT, 65535: cycles allowed in a busy state before the packet is forced to error (range 1..65535).

Ports:
- nRst  in  1  asynchronous active-low reset
- clk  in  1  system clock
- ownAddr  in  8  bridge address
- inPacketStart  in  1  one-cycle strobe; inAddr, inCmdCode and inSize are valid in the same cycle
- inPacketEnd  in  1  one-cycle strobe: checksum ok
- inPacketErr  in  1  one-cycle strobe: checksum or framing error
- inAddr  in  8  packet address
- inCmdCode  in  8  raw command byte (A0 reset, A2 send data, B0 status, B2 receive data)
- inSize  in  8  requested or declared word count
- rxUsed  in  16  words held in the MIL receive buffer
- outEnable  out  1  reply path armed
- outAddr  out  8  reply address
- outSize  out  8  reply word count
- outSel  out  1  reply source: 0 = receive buffer, 1 = status words
- statusWord0  out  16  {errCount, okCount}
- statusWord1  out  16  rxUsed latched at packet start
- txCommit  out  1  one-cycle pulse: keep the written transmit data
- txRollback  out  1  one-cycle pulse: discard the written transmit data
- rxCommit  out  1  one-cycle pulse: release the popped receive words
- rxRollback  out  1  one-cycle pulse: restore the popped receive words
- rstRequest  out  1  system reset request

Behaviour:
- Reset: asynchronous on nRst low.
  - All outputs 0, counters 0, state IDLE.
  - Reset takes effect immediately mid-packet; no commit or rollback pulse is generated for the interrupted packet.
- States: IDLE, SEND, STS, RECV, RST, IGNORE.
- Address match: inAddr == ownAddr, sampled on inPacketStart.
- Start handling (IDLE and inPacketStart); the new state takes effect next cycle:
  - Match, A2 -> SEND.
  - Match, B0 -> STS. Latch statusWord1 = rxUsed. outSel = 1, outSize = 2, outAddr = ownAddr, outEnable = 1.
  - Match, B2 -> RECV. outSel = 0, outSize = min(inSize, rxUsed[7:0]) (rxUsed >= 256 saturates to 255), outAddr = ownAddr, outEnable = 1.
  - Match, A0 -> IGNORE-like wait for end; reset is acted on only at inPacketEnd.
  - Mismatch or unknown code -> IGNORE.
- End/error handling (busy state). All listed pulses happen the cycle after the strobe, with return to IDLE:
  - SEND: end -> txCommit; err -> txRollback.
  - RECV: end -> rxCommit; err -> rxRollback.
  - STS: no buffer action.
  - Matched A0: end -> RST.
  - IGNORE: no action, no counter change.
  - outEnable drops to 0 in the same cycle as the pulse.
- Counters (matched packets only; 8-bit, saturating at 255):
  - okCount increments on inPacketEnd.
  - errCount increments on inPacketErr or timeout.
  - statusWord0 updates the cycle after an increment.
- RST:
  - rstRequest is held 1 for exactly RESET_LEN cycles, then returns to IDLE.
  - Counters clear in the last cycle of the pulse.
  - Strobes arriving during RST are ignored.
- Timeout:
  - The cycle counter restarts on entry to each busy state.
  - On reaching TIMEOUT without end/err: treat as inPacketErr, including rollback and errCount++.
- Simultaneous events:
  - inPacketEnd and inPacketErr together: err wins.
  - inPacketStart in a busy state: the current packet is treated as err (rollback, errCount++ if matched). The new start is dropped and the state returns to IDLE.
  - inPacketStart together with end/err in IDLE: end/err ignored, start accepted.
- Pulse exclusivity: at most one of txCommit, txRollback, rxCommit, rxRollback is high in any cycle.

Test Plan:
- ownAddr = AB. Start(AB, A2, size 8), then inPacketEnd -> one txCommit pulse 1 cycle later; okCount = 1; statusWord0 = 16'h0001.
- Same packet closed with inPacketErr -> txRollback pulse; statusWord0 = 16'h0101; no txCommit.
- rxUsed = 5, start(AB, B2, size 10) -> next cycle outEnable = 1, outSel = 0, outSize = 5, outAddr = AB. On end: rxCommit pulse, outEnable = 0.
- rxUsed = 300, start(AB, B0) -> outSel = 1, outSize = 2, statusWord1 = 16'd300. On end: no buffer pulses, okCount++.
- Start(01, A0), then end -> rstRequest stays 0, counters unchanged. Start(AB, A0), then end -> rstRequest high for exactly 16 cycles, counters cleared afterwards.
- TIMEOUT = 100: start(AB, A2) with no end -> txRollback at cycle 100, errCount = 1. Then assert nRst low mid-RECV -> all outputs 0 immediately, no pulses.

Source files
------------

// File: rtl/link_spi_controller_if.sv
// Link-layer strobes in, reply-path configuration and buffer commit/rollback out.
// The controller attaches through the slave modport; the link side uses master.
interface link_spi_controller_if;
    logic [7:0]  ownAddr;
    logic        inPacketStart;
    logic        inPacketEnd;
    logic        inPacketErr;
    logic [7:0]  inAddr;
    logic [7:0]  inCmdCode;
    logic [7:0]  inSize;
    logic [15:0] rxUsed;
    logic        outEnable;
    logic [7:0]  outAddr;
    logic [7:0]  outSize;
    logic        outSel;
    logic [15:0] statusWord0;
    logic [15:0] statusWord1;
    logic        txCommit;
    logic        txRollback;
    logic        rxCommit;
    logic        rxRollback;
    logic        rstRequest;

    modport slave (
        input  ownAddr, inPacketStart, inPacketEnd, inPacketErr,
               inAddr, inCmdCode, inSize, rxUsed,
        output outEnable, outAddr, outSize, outSel, statusWord0, statusWord1,
               txCommit, txRollback, rxCommit, rxRollback, rstRequest
    );

    modport master (
        output ownAddr, inPacketStart, inPacketEnd, inPacketErr,
               inAddr, inCmdCode, inSize, rxUsed,
        input  outEnable, outAddr, outSize, outSel, statusWord0, statusWord1,
               txCommit, txRollback, rxCommit, rxRollback, rstRequest
    );
endinterface

// File: rtl/link_spi_controller.sv
// Packet-level sequencer for the SPI link: buffer commit/rollback, reply arming,
// system reset request and the ok/error counters returned in the status reply.
module link_spi_controller #(
    parameter int unsigned RESET_LEN = 16,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic                        clk,
    input  logic                        nRst,
    link_spi_controller_if.slave        lnk
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMO_W = 16;
    localparam int unsigned RST_W = 8;

    localparam logic [7:0] CMD_RESET  = 8'hA0;
    localparam logic [7:0] CMD_SEND   = 8'hA2;
    localparam logic [7:0] CMD_STATUS = 8'hB0;
    localparam logic [7:0] CMD_RECV   = 8'hB2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND   = 3'd1,
        STS    = 3'd2,
        RECV   = 3'd3,
        RST    = 3'd4,
        IGNORE = 3'd5
    } state_t;

    state_t             state;
    logic               rst_armed;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [RST_W-1:0]   rst_cnt;
    logic [CNT_W-1:0]   ok_cnt;
    logic [CNT_W-1:0]   err_cnt;

    logic               out_enable;
    logic [7:0]         out_addr;
    logic [7:0]         out_size;
    logic               out_sel;
    logic [15:0]        status_word1;
    logic               tx_commit;
    logic               tx_rollback;
    logic               rx_commit;
    logic               rx_rollback;
    logic               rst_request;

    logic               addr_match_c;
    logic [7:0]         rx_sat_c;
    logic [7:0]         recv_size_c;
    logic               tmo_hit_c;
    logic               close_err_c;
    logic               close_ok_c;
    logic               counted_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Packet classification and close conditions; a start seen while busy aborts the packet.
    always_comb begin
        addr_match_c = (lnk.inAddr == lnk.ownAddr);
        rx_sat_c     = (|lnk.rxUsed[15:8]) ? 8'hFF : lnk.rxUsed[7:0];
        recv_size_c  = (lnk.inSize < rx_sat_c) ? lnk.inSize : rx_sat_c;
        tmo_hit_c    = (tmo_cnt == TMO_W'(TIMEOUT - 1));
        close_err_c  = lnk.inPacketErr | lnk.inPacketStart | tmo_hit_c;
        close_ok_c   = lnk.inPacketEnd & ~close_err_c;
        counted_c    = (state != IGNORE) | rst_armed;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state        <= IDLE;
            rst_armed    <= 1'b0;
            tmo_cnt      <= '0;
            rst_cnt      <= '0;
            ok_cnt       <= '0;
            err_cnt      <= '0;
            out_enable   <= 1'b0;
            out_addr     <= '0;
            out_size     <= '0;
            out_sel      <= 1'b0;
            status_word1 <= '0;
            tx_commit    <= 1'b0;
            tx_rollback  <= 1'b0;
            rx_commit    <= 1'b0;
            rx_rollback  <= 1'b0;
            rst_request  <= 1'b0;
        end else begin
            tx_commit   <= 1'b0;
            tx_rollback <= 1'b0;
            rx_commit   <= 1'b0;
            rx_rollback <= 1'b0;

            case (state)
                IDLE: begin
                    if (lnk.inPacketStart) begin
                        tmo_cnt   <= '0;
                        rst_armed <= 1'b0;
                        if (!addr_match_c) begin
                            state <= IGNORE;
                        end else begin
                            case (lnk.inCmdCode)
                                CMD_SEND: state <= SEND;
                                CMD_STATUS: begin
                                    state        <= STS;
                                    status_word1 <= lnk.rxUsed;
                                    out_sel      <= 1'b1;
                                    out_size     <= 8'd2;
                                    out_addr     <= lnk.ownAddr;
                                    out_enable   <= 1'b1;
                                end
                                CMD_RECV: begin
                                    state      <= RECV;
                                    out_sel    <= 1'b0;
                                    out_size   <= recv_size_c;
                                    out_addr   <= lnk.ownAddr;
                                    out_enable <= 1'b1;
                                end
                                // Reset request waits for a clean end before acting.
                                CMD_RESET: begin
                                    state     <= IGNORE;
                                    rst_armed <= 1'b1;
                                end
                                default: state <= IGNORE;
                            endcase
                        end
                    end
                end

                SEND, STS, RECV, IGNORE: begin
                    if (close_err_c || close_ok_c) begin
                        state      <= IDLE;
                        out_enable <= 1'b0;
                        rst_armed  <= 1'b0;
                        if (counted_c) begin
                            if (close_err_c) begin
                                err_cnt <= sat_inc(err_cnt);
                            end else begin
                                ok_cnt <= sat_inc(ok_cnt);
                            end
                        end
                        if (state == SEND) begin
                            tx_commit   <= close_ok_c;
                            tx_rollback <= close_err_c;
                        end
                        if (state == RECV) begin
                            rx_commit   <= close_ok_c;
                            rx_rollback <= close_err_c;
                        end
                        if ((state == IGNORE) && rst_armed && close_ok_c) begin
                            state       <= RST;
                            rst_request <= 1'b1;
                            rst_cnt     <= RST_W'(RESET_LEN - 1);
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                // Link strobes are ignored for the whole reset pulse.
                RST: begin
                    if (rst_cnt == '0) begin
                        rst_request <= 1'b0;
                        state       <= IDLE;
                        ok_cnt      <= '0;
                        err_cnt     <= '0;
                    end else begin
                        rst_cnt <= rst_cnt - RST_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign lnk.outEnable   = out_enable;
    assign lnk.outAddr     = out_addr;
    assign lnk.outSize     = out_size;
    assign lnk.outSel      = out_sel;
    assign lnk.statusWord0 = {err_cnt, ok_cnt};
    assign lnk.statusWord1 = status_word1;
    assign lnk.txCommit    = tx_commit;
    assign lnk.txRollback  = tx_rollback;
    assign lnk.rxCommit    = rx_commit;
    assign lnk.rxRollback  = rx_rollback;
    assign lnk.rstRequest  = rst_request;

endmodule

// File: tb/tb_link_spi_controller.sv
// Randomized packet bench for link_spi_controller: a packet-level model queues the
// expected output events, and a monitor pops and compares them as the DUT produces them.
module tb_link_spi_controller;

    localparam int unsigned RESET_LEN = 16;
    localparam int unsigned TIMEOUT   = 100;
    localparam logic [7:0]  OWN       = 8'hAB;

    localparam int C_END = 0, C_ERR = 1, C_BOTH = 2, C_TMO = 3, C_RESTART = 4;

    typedef enum int {EV_ARM, EV_DISARM, EV_TXC, EV_TXR, EV_RXC, EV_RXR, EV_RST} ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        int          cyc;
        logic [7:0]  size;
        logic [7:0]  addr;
        logic        sel;
        logic [15:0] sw1;
        bit          chk_sw1;
        logic [15:0] sw0;
        bit          chk_sw0;
    } ev_t;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    link_spi_controller_if lif ();

    link_spi_controller #(.RESET_LEN(RESET_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .nRst (nRst),
        .lnk  (lif)
    );

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  ok_m  = 0;
    int  err_m = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic ev_t mk(input ev_kind_t kd, input int c);
        ev_t r;
        r.kind = kd; r.cyc = c; r.size = '0; r.addr = '0; r.sel = 1'b0;
        r.sw1 = '0; r.chk_sw1 = 1'b0; r.sw0 = '0; r.chk_sw0 = 1'b0;
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    function automatic logic [15:0] sw0_model();
        return {8'(err_m), 8'(ok_m)};
    endfunction

    // Monitor: every DUT output event must match the head of the expectation queue.
    task automatic check_ev(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected event %s at cycle %0d: got event expected none", k.name(), cyc);
            return;
        end
        e = exp_q.pop_front();
        cmp($sformatf("event kind (%s)", k.name()), 32'(k), 32'(e.kind));
        cmp($sformatf("event cycle (%s)", k.name()), 32'(cyc), 32'(e.cyc));
        if (k == EV_ARM && e.kind == EV_ARM) begin
            cmp("outSize", 32'(lif.outSize), 32'(e.size));
            cmp("outAddr", 32'(lif.outAddr), 32'(e.addr));
            cmp("outSel",  32'(lif.outSel),  32'(e.sel));
            if (e.chk_sw1) cmp("statusWord1", 32'(lif.statusWord1), 32'(e.sw1));
        end
        if (e.chk_sw0) cmp("statusWord0 at event", 32'(lif.statusWord0), 32'(e.sw0));
    endtask

    logic prev_en  = 1'b0;
    logic prev_rst = 1'b0;
    int   rst_len  = 0;

    always @(negedge clk) begin
        if (lif.txCommit   === 1'b1) check_ev(EV_TXC);
        if (lif.txRollback === 1'b1) check_ev(EV_TXR);
        if (lif.rxCommit   === 1'b1) check_ev(EV_RXC);
        if (lif.rxRollback === 1'b1) check_ev(EV_RXR);
        if (prev_en && lif.outEnable !== 1'b1) check_ev(EV_DISARM);
        if (!prev_rst && lif.rstRequest === 1'b1) check_ev(EV_RST);
        if (prev_rst && lif.rstRequest !== 1'b1) cmp("rstRequest width", 32'(rst_len), 32'(RESET_LEN));
        rst_len = (lif.rstRequest === 1'b1) ? rst_len + 1 : 0;
        if (!prev_en && lif.outEnable === 1'b1) check_ev(EV_ARM);
        prev_en  = (lif.outEnable === 1'b1);
        prev_rst = (lif.rstRequest === 1'b1);
    end

    task automatic clear_strobes();
        lif.inPacketStart = 1'b0;
        lif.inPacketEnd   = 1'b0;
        lif.inPacketErr   = 1'b0;
        lif.inAddr        = 8'($urandom);
        lif.inCmdCode     = 8'($urandom);
        lif.inSize        = 8'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, " outEnable"},   32'(lif.outEnable),   32'd0);
        cmp({tag, " outAddr"},     32'(lif.outAddr),     32'd0);
        cmp({tag, " outSize"},     32'(lif.outSize),     32'd0);
        cmp({tag, " outSel"},      32'(lif.outSel),      32'd0);
        cmp({tag, " statusWord0"}, 32'(lif.statusWord0), 32'd0);
        cmp({tag, " statusWord1"}, 32'(lif.statusWord1), 32'd0);
        cmp({tag, " pulses"}, 32'({lif.txCommit, lif.txRollback, lif.rxCommit, lif.rxRollback}), 32'd0);
        cmp({tag, " rstRequest"},  32'(lif.rstRequest),  32'd0);
    endtask

    // One packet: start, then a close after d cycles (or nothing, to force a timeout).
    task automatic packet(input logic [7:0] addr, input logic [7:0] cmd, input logic [7:0] size,
                          input logic [15:0] used, input int close, input int d,
                          input bit idle_junk, input bit rst_junk);
        int k, m;
        bit known, counted, err;
        ev_t e;
        int rs;
        @(posedge clk); #1;
        lif.inAddr = addr; lif.inCmdCode = cmd; lif.inSize = size; lif.rxUsed = used;
        lif.inPacketStart = 1'b1;
        if (idle_junk) begin
            lif.inPacketEnd = 1'($urandom_range(0, 1));
            lif.inPacketErr = ~lif.inPacketEnd;
        end
        k = cyc + 1;
        known   = (cmd == 8'hA0) || (cmd == 8'hA2) || (cmd == 8'hB0) || (cmd == 8'hB2);
        counted = (addr == OWN) && known;
        if (counted && cmd == 8'hB0) begin
            e = mk(EV_ARM, k); e.sel = 1'b1; e.size = 8'd2; e.addr = OWN;
            e.sw1 = used; e.chk_sw1 = 1'b1;
            exp_q.push_back(e);
        end
        if (counted && cmd == 8'hB2) begin
            rs = (int'(used) > 255) ? 255 : int'(used);
            if (int'(size) < rs) rs = int'(size);
            e = mk(EV_ARM, k); e.sel = 1'b0; e.size = 8'(rs); e.addr = OWN;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        clear_strobes();
        if (close == C_TMO) begin
            m = k + int'(TIMEOUT);
            repeat (TIMEOUT) @(posedge clk);
            #1;
        end else begin
            repeat (d - 1) @(posedge clk);
            #1;
            case (close)
                C_END:   lif.inPacketEnd = 1'b1;
                C_ERR:   lif.inPacketErr = 1'b1;
                C_BOTH:  begin lif.inPacketEnd = 1'b1; lif.inPacketErr = 1'b1; end
                default: begin
                    lif.inPacketStart = 1'b1; lif.inAddr = OWN; lif.inCmdCode = 8'hA2;
                end
            endcase
            m = cyc + 1;
            @(posedge clk); #1;
            clear_strobes();
        end
        err = (close != C_END);
        if (counted) begin
            if (err) err_m = sat(err_m);
            else     ok_m  = sat(ok_m);
        end
        if (counted && cmd == 8'hA2) begin
            e = mk(err ? EV_TXR : EV_TXC, m); e.sw0 = sw0_model(); e.chk_sw0 = 1'b1;
            exp_q.push_back(e);
        end
        if (counted && cmd == 8'hB2) begin
            e = mk(err ? EV_RXR : EV_RXC, m); e.sw0 = sw0_model(); e.chk_sw0 = 1'b1;
            exp_q.push_back(e);
            e = mk(EV_DISARM, m);
            exp_q.push_back(e);
        end
        if (counted && cmd == 8'hB0) begin
            e = mk(EV_DISARM, m); e.sw0 = sw0_model(); e.chk_sw0 = 1'b1;
            exp_q.push_back(e);
        end
        if (counted && cmd == 8'hA0 && !err) begin
            exp_q.push_back(mk(EV_RST, m));
            if (rst_junk) begin
                repeat (5) @(posedge clk);
                #1;
                lif.inPacketStart = 1'b1; lif.inAddr = OWN; lif.inCmdCode = 8'hA2;
                lif.inPacketEnd = 1'b1;
                @(posedge clk); #1;
                clear_strobes();
                repeat (RESET_LEN - 5) @(posedge clk);
            end else begin
                repeat (RESET_LEN) @(posedge clk);
            end
            ok_m  = 0;
            err_m = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        cmp("statusWord0 after packet", 32'(lif.statusWord0), 32'(sw0_model()));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within cycle budget");
        $fatal(1);
    end

    initial begin
        logic [7:0] cmds[5];
        int pick, close, rs_k;
        logic [7:0] a, c;
        ev_t e;
        cmds[0] = 8'hA0; cmds[1] = 8'hA2; cmds[2] = 8'hB0; cmds[3] = 8'hB2; cmds[4] = 8'h00;

        lif.ownAddr = OWN;
        lif.rxUsed  = '0;
        clear_strobes();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        nRst = 1'b1;
        repeat (2) @(posedge clk);

        packet(OWN, 8'hA2, 8'd8, 16'd0, C_END, 3, 1'b0, 1'b0);
        packet(OWN, 8'hA2, 8'd8, 16'd0, C_ERR, 3, 1'b0, 1'b0);
        packet(OWN, 8'hB2, 8'd10, 16'd5, C_END, 4, 1'b0, 1'b0);
        packet(OWN, 8'hB0, 8'd0, 16'd300, C_END, 4, 1'b0, 1'b0);
        packet(8'h01, 8'hA0, 8'd0, 16'd0, C_END, 2, 1'b0, 1'b0);
        packet(OWN, 8'hA0, 8'd0, 16'd0, C_END, 2, 1'b0, 1'b1);
        packet(OWN, 8'hA2, 8'd8, 16'd0, C_TMO, 0, 1'b0, 1'b0);
        packet(OWN, 8'hB2, 8'd200, 16'd1000, C_BOTH, 5, 1'b1, 1'b0);
        packet(OWN, 8'hB2, 8'd3, 16'd40, C_RESTART, 2, 1'b0, 1'b0);
        packet(OWN, 8'hB0, 8'd0, 16'd7, C_TMO, 0, 1'b0, 1'b0);

        // Drive both counters into saturation.
        for (int i = 0; i < 260; i++) packet(OWN, 8'hA2, 8'd1, 16'd0, C_END, 1, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) packet(OWN, 8'hA2, 8'd1, 16'd0, C_ERR, 1, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            a = ($urandom_range(0, 9) < 8) ? OWN : 8'($urandom);
            pick = $urandom_range(0, 9);
            c = (pick < 2) ? cmds[0] : (pick < 4) ? cmds[1] : (pick < 6) ? cmds[2] :
                (pick < 9) ? cmds[3] : 8'($urandom);
            pick = $urandom_range(0, 9);
            close = (pick < 5) ? C_END : (pick < 7) ? C_ERR : (pick == 7) ? C_BOTH :
                    (pick == 8) ? C_RESTART : (($urandom_range(0, 3) == 0) ? C_TMO : C_END);
            packet(a, c, 8'($urandom), 16'($urandom_range(0, 400)), close,
                   $urandom_range(1, 20), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a receive packet.
        @(posedge clk); #1;
        lif.inAddr = OWN; lif.inCmdCode = 8'hB2; lif.inSize = 8'd50; lif.rxUsed = 16'd30;
        lif.inPacketStart = 1'b1;
        rs_k = cyc + 1;
        e = mk(EV_ARM, rs_k); e.size = 8'd30; e.addr = OWN; e.sel = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        clear_strobes();
        repeat (3) @(posedge clk);
        #1;
        e = mk(EV_DISARM, cyc); e.sw0 = 16'd0; e.chk_sw0 = 1'b1;
        exp_q.push_back(e);
        nRst = 1'b0;
        #1;
        check_all_zero("async reset");
        lif.inPacketEnd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clear_strobes();
        nRst  = 1'b1;
        ok_m  = 0;
        err_m = 0;
        repeat (5) @(posedge clk);
        #1;
        check_all_zero("after reset");
        cmp("pending expected events", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
